// File: rtl/baud_rate_ctrl.sv
// Run-time UART baud-rate controller: 8-entry divisor table, phase-locked x16/x1 ticks,
// and a 4-phase req/ack rate change applied only on an x1 (bit) boundary.
module baud_rate_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int RESET_SEL  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       cfg_req,
  input  logic [2:0] cfg_sel,
  output logic       cfg_ack,
  output logic       busy,
  output logic [2:0] cur_sel,
  output logic       tick_x16,
  output logic       tick_x1
);

  localparam int SUB_W = $clog2(OVERSAMPLE);

  typedef enum logic [1:0] {RUN, PEND, ACK} state_t;

  // Rounded divisor for each standard rate; folds to constants at elaboration.
  function automatic logic [DIV_W-1:0] div_of(input logic [2:0] sel);
    longint baud;
    longint step;
    case (sel)
      3'd0:    baud = 1200;
      3'd1:    baud = 2400;
      3'd2:    baud = 4800;
      3'd3:    baud = 9600;
      3'd4:    baud = 19200;
      3'd5:    baud = 38400;
      3'd6:    baud = 57600;
      default: baud = 115200;
    endcase
    step = baud * longint'(OVERSAMPLE);
    return DIV_W'((longint'(CLK_HZ) + step / 2) / step);
  endfunction

  state_t           state, next_state;
  logic [2:0]       pend_sel;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;
  logic [SUB_W-1:0] sub_cnt;
  logic             term16, term1, apply;

  always_comb begin
    div_last = div_of(cur_sel) - DIV_W'(1);
    term16   = en && (div_cnt == div_last);
    term1    = term16 && (sub_cnt == SUB_W'(OVERSAMPLE - 1));
    // A disabled generator has no bit in flight, so a pending change applies at once.
    apply    = (state == PEND) && (term1 || !en);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= next_state;
  end

  // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (cfg_req) next_state = PEND;
      PEND:    if (apply)   next_state = ACK;
      ACK:     if (!cfg_req) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    busy    = (state != RUN);
    cfg_ack = (state == ACK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_sel <= 3'(RESET_SEL);
      cur_sel  <= 3'(RESET_SEL);
    end else begin
      if (state == RUN && cfg_req) pend_sel <= cfg_sel;
      if (apply)                   cur_sel  <= pend_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      sub_cnt  <= '0;
      tick_x16 <= 1'b0;
      tick_x1  <= 1'b0;
    end else begin
      tick_x16 <= term16;
      tick_x1  <= term1;
      if (!en || apply) begin
        div_cnt <= '0;
        sub_cnt <= '0;
      end else if (term16) begin
        div_cnt <= '0;
        sub_cnt <= term1 ? '0 : sub_cnt + SUB_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_baud_rate_ctrl.sv
// Self-checking bench for baud_rate_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a phase-counting reference model.
module tb_baud_rate_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       en = 1'b0;
  logic       cfg_req = 1'b0;
  logic [2:0] cfg_sel = 3'd0;
  logic       cfg_ack, busy, tick_x16, tick_x1;
  logic [2:0] cur_sel;

  int n_cmp  = 0;
  int n_fail = 0;

  baud_rate_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .cfg_req  (cfg_req),
    .cfg_sel  (cfg_sel),
    .cfg_ack  (cfg_ack),
    .busy     (busy),
    .cur_sel  (cur_sel),
    .tick_x16 (tick_x16),
    .tick_x1  (tick_x1)
  );

  always #5 clk = ~clk;

  // Reference model: ticks fall where the count of enabled edges since the last
  // phase restart is a multiple of the divisor (x16) or of 16 divisors (x1).
  typedef enum {M_RUN, M_PEND, M_ACK} mstate_t;
  mstate_t m_st;
  int      m_phase, m_cur, m_pend;
  bit      m_t16, m_t1;

  function automatic int div_of(input int sel);
    int bauds [8];
    bauds = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};
    return (50_000_000 + bauds[sel] * 8) / (bauds[sel] * 16);
  endfunction

  task automatic model_reset();
    m_st = M_RUN; m_phase = 0; m_cur = 3; m_pend = 3; m_t16 = 0; m_t1 = 0;
  endtask

  task automatic model_step();
    int d;
    d = div_of(m_cur);
    if (en) begin
      m_phase++;
      m_t16 = (m_phase % d) == 0;
      m_t1  = (m_phase % (16 * d)) == 0;
    end else begin
      m_phase = 0; m_t16 = 0; m_t1 = 0;
    end
    case (m_st)
      M_RUN:  if (cfg_req) begin m_pend = int'(cfg_sel); m_st = M_PEND; end
      M_PEND: if (!en || m_t1) begin m_cur = m_pend; m_phase = 0; m_st = M_ACK; end
      M_ACK:  if (!cfg_req) m_st = M_RUN;
      default: m_st = M_RUN;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tick_x16", 32'(tick_x16), 32'(m_t16));
    check("tick_x1",  32'(tick_x1),  32'(m_t1));
    check("cur_sel",  32'(cur_sel),  32'(m_cur));
    check("cfg_ack",  32'(cfg_ack),  32'(m_st == M_ACK));
    check("busy",     32'(busy),     32'(m_st != M_RUN));
  endtask

  task automatic wait_x16(input int budget, output int cnt);
    cnt = 0;
    do begin cycle(); cnt++; end while (!tick_x16 && cnt < budget);
  endtask

  task automatic wait_x1(input int budget, output int cnt);
    cnt = 0;
    do begin cycle(); cnt++; end while (!tick_x1 && cnt < budget);
  endtask

  task automatic wait_ack(input int budget, output int cnt);
    cnt = 0;
    do begin cycle(); cnt++; end while (!cfg_ack && cnt < budget);
  endtask

  initial begin
    int cnt;
    int gap_ticks;

    // Reset state
    #1 reset_n = 1'b0;
    en = 1'b1;
    #2;
    check("rst_tick_x16", 32'(tick_x16), 32'd0);
    check("rst_tick_x1",  32'(tick_x1),  32'd0);
    check("rst_ack",      32'(cfg_ack),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_cur_sel",  32'(cur_sel),  32'd3);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();

    // 1/2: default rate, then switch to 115200 requested at cycle 1000
    wait_x16(400, cnt);
    check("t1_first_x16", 32'(cnt), 32'd326);
    repeat (1000 - 326) cycle();
    cfg_req = 1'b1; cfg_sel = 3'd7;
    cycle();
    check("t2_busy", 32'(busy), 32'd1);
    wait_ack(6000, cnt);
    check("t2_ack_cycle", 32'(cnt + 1001), 32'd5216);
    check("t2_ack_x1",    32'(tick_x1),    32'd1);
    check("t2_ack_x16",   32'(tick_x16),   32'd1);
    check("t2_cur_sel",   32'(cur_sel),    32'd7);
    cfg_req = 1'b0;
    cycle();
    check("t2_ack_fall", 32'(cfg_ack), 32'd0);
    wait_x16(100, cnt);
    wait_x16(100, cnt);
    check("t2_x16_period", 32'(cnt), 32'd27);
    wait_x1(1000, cnt);
    wait_x1(1000, cnt);
    check("t2_x1_period", 32'(cnt), 32'd432);

    // 3: change while disabled applies two edges later
    en = 1'b0; cfg_req = 1'b1; cfg_sel = 3'd0;
    cycle();
    check("t3_busy", 32'(busy), 32'd1);
    cycle();
    check("t3_ack",     32'(cfg_ack), 32'd1);
    check("t3_cur_sel", 32'(cur_sel), 32'd0);
    check("t3_no_tick", 32'(tick_x16), 32'd0);
    cfg_req = 1'b0;
    cycle();
    en = 1'b1;
    wait_x16(3000, cnt);
    check("t3_first_x16", 32'(cnt), 32'd2604);

    // 4: 100-cycle enable gap mid-count
    repeat (1000) cycle();
    en = 1'b0;
    gap_ticks = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (tick_x16 || tick_x1) gap_ticks++;
    end
    check("t4_gap_ticks", 32'(gap_ticks), 32'd0);
    en = 1'b1;
    wait_x16(3000, cnt);
    check("t4_restart_x16", 32'(cnt), 32'd2604);

    // 5: async reset while a change is pending
    cfg_req = 1'b1; cfg_sel = 3'd5;
    cycle();
    wait_x16(3000, cnt);
    check("t5_pre_busy", 32'(busy),     32'd1);
    check("t5_pre_tick", 32'(tick_x16), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_ack",  32'(cfg_ack),  32'd0);
    check("t5_rst_busy", 32'(busy),     32'd0);
    check("t5_rst_x16",  32'(tick_x16), 32'd0);
    check("t5_rst_x1",   32'(tick_x1),  32'd0);
    check("t5_rst_sel",  32'(cur_sel),  32'd3);
    @(posedge clk); #1;
    cfg_req = 1'b0;
    reset_n = 1'b1;
    model_reset();
    wait_x16(400, cnt);
    check("t5_first_x16", 32'(cnt), 32'd326);
    wait_x16(400, cnt);
    check("t5_x16_period", 32'(cnt), 32'd326);

    // 6: request held past ack with cfg_sel toggling
    cfg_req = 1'b1; cfg_sel = 3'd6;
    wait_ack(6000, cnt);
    check("t6_ack", 32'(cfg_ack), 32'd1);
    for (int i = 0; i < 50; i++) begin
      cfg_sel = 3'($urandom_range(0, 7));
      cycle();
    end
    check("t6_held_ack", 32'(cfg_ack), 32'd1);
    check("t6_held_sel", 32'(cur_sel), 32'd6);
    cfg_req = 1'b0;
    cycle();
    check("t6_ack_fall", 32'(cfg_ack), 32'd0);

    // Randomized traffic under the protocol, biased toward fast rates
    for (int i = 0; i < 30000; i++) begin
      if (en) begin
        if ($urandom_range(0, 2999) == 0) en = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        en = 1'b1;
      end
      if (!cfg_req) begin
        if ($urandom_range(0, 199) == 0) cfg_req = 1'b1;
      end else if (m_st == M_ACK && $urandom_range(0, 3) == 0) begin
        cfg_req = 1'b0;
      end
      cfg_sel = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                            : 3'($urandom_range(4, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
